// File: rtl/seq_shift_unit.sv
// Sequential shift/rotate unit: captures an operand on start, moves it one bit
// per clock for amt steps, then pulses done with the result and last bit out.
module seq_shift_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic [2:0]       mode_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic             serial_in_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] dout_o,
    output logic             carry_out_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [2:0] M_PASS = 3'b000;
    localparam logic [2:0] M_SHL  = 3'b001;
    localparam logic [2:0] M_SHR  = 3'b010;
    localparam logic [2:0] M_ROR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ASR  = 3'b101;
    localparam logic [2:0] M_SHLS = 3'b110;
    localparam logic [2:0] M_SHRS = 3'b111;

    state_t           state_q;
    logic [WIDTH-1:0] dout_q;
    logic             carry_q;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       mode_q;
    logic [AMT_W-1:0] count_q;

    logic [WIDTH-1:0] shift_d;
    logic             carry_d;

    // One step of the captured operation applied to the current word.
    always_comb begin
        shift_d = dout_q;
        carry_d = carry_q;
        case (mode_q)
            M_SHL: begin
                shift_d = {dout_q[WIDTH-2:0], 1'b0};
                carry_d = dout_q[WIDTH-1];
            end
            M_SHR: begin
                shift_d = {1'b0, dout_q[WIDTH-1:1]};
                carry_d = dout_q[0];
            end
            M_ROR: begin
                shift_d = {dout_q[0], dout_q[WIDTH-1:1]};
                carry_d = dout_q[0];
            end
            M_ROL: begin
                shift_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
                carry_d = dout_q[WIDTH-1];
            end
            M_ASR: begin
                shift_d = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
                carry_d = dout_q[0];
            end
            M_SHLS: begin
                shift_d = {dout_q[WIDTH-2:0], serial_in_i};
                carry_d = dout_q[WIDTH-1];
            end
            M_SHRS: begin
                shift_d = {serial_in_i, dout_q[WIDTH-1:1]};
                carry_d = dout_q[0];
            end
            default: begin
                shift_d = dout_q;
                carry_d = carry_q;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            dout_q  <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= M_PASS;
            count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        dout_q  <= din_i;
                        mode_q  <= mode_i;
                        count_q <= amt_i;
                        carry_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (amt_i == '0 || mode_i == M_PASS) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    dout_q  <= shift_d;
                    carry_q <= carry_d;
                    count_q <= count_q - 1'b1;
                    // Last step: done rises in the same cycle the final value lands.
                    if (count_q == AMT_W'(1)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign dout_o      = dout_q;
    assign carry_out_o = carry_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: directed cases plus random operations compared
// against a whole-operation arithmetic model.
module tb_seq_shift_unit;

    localparam int W     = 8;
    localparam int AMT_W = 3;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             start_i = 1'b0;
    logic [W-1:0]     din_i = '0;
    logic [2:0]       mode_i = '0;
    logic [AMT_W-1:0] amt_i = '0;
    logic             serial_in_i = 1'b0;
    logic             busy_o;
    logic             done_o;
    logic [W-1:0]     dout_o;
    logic             carry_out_o;

    int n_checks = 0;
    int n_fail   = 0;

    seq_shift_unit #(.WIDTH(W), .AMT_W(AMT_W)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .din_i      (din_i),
        .mode_i     (mode_i),
        .amt_i      (amt_i),
        .serial_in_i(serial_in_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .dout_o     (dout_o),
        .carry_out_o(carry_out_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Result of n steps computed in one go; sb[k] is the fill bit of step k.
    function automatic void ref_op(input logic [W-1:0] d, input logic [2:0] m, input int n,
                                   input logic [15:0] sb, output logic [W-1:0] r, output logic c);
        logic [2*W:0]   wl;
        logic [W+W:0]   wr;
        logic [2*W-1:0] dd;
        logic [W-1:0]   f;
        int             rn;
        r  = d;
        c  = 1'b0;
        f  = '0;
        rn = n % W;
        if (m == 3'b000 || n == 0) return;
        case (m)
            3'b001, 3'b110: begin
                if (m == 3'b110)
                    for (int k = 0; k < n && k < W; k++) f[W-1-k] = sb[k];
                wl = {1'b0, d, f} << n;
                r  = wl[2*W-1:W];
                c  = wl[2*W];
            end
            3'b010, 3'b111, 3'b101: begin
                if (m == 3'b111)
                    for (int k = 0; k < n && k < W; k++) f[k] = sb[k];
                if (m == 3'b101) f = {W{d[W-1]}};
                wr = {f, d, 1'b0} >> n;
                r  = wr[W:1];
                c  = wr[0];
            end
            3'b011: begin
                dd = {d, d} >> rn;
                r  = dd[W-1:0];
                c  = r[W-1];
            end
            default: begin
                dd = {d, d} << rn;
                r  = dd[2*W-1:W];
                c  = r[0];
            end
        endcase
    endfunction

    // Called at a negedge with the unit idle; returns at the negedge after done falls.
    // noise: 0 quiet, 1 random start/operands while busy, 2 start with din=0xFF while busy.
    task automatic run_op(input logic [W-1:0] d, input logic [2:0] m, input logic [AMT_W-1:0] a,
                          input logic [15:0] sb, input int noise);
        int           n;
        logic [W-1:0] er;
        logic         ec;
        n = (m == 3'b000) ? 0 : int'(a);
        start_i     = 1'b1;
        din_i       = d;
        mode_i      = m;
        amt_i       = a;
        serial_in_i = sb[0];
        for (int j = 0; j <= n + 1; j++) begin
            @(negedge clk_i);
            if (j <= n && noise == 1) begin
                start_i = 1'($urandom);
                din_i   = W'($urandom);
                mode_i  = 3'($urandom);
                amt_i   = AMT_W'($urandom);
            end else if (j <= n && noise == 2) begin
                start_i = 1'b1;
                din_i   = '1;
            end else begin
                start_i = 1'b0;
            end
            if (j < n) serial_in_i = sb[j];
            else       serial_in_i = 1'($urandom);
            ref_op(d, m, (j <= n) ? j : n, sb, er, ec);
            check_val($sformatf("busy m%0d j%0d", m, j), 32'(busy_o), 32'(j <= n));
            check_val($sformatf("done m%0d j%0d", m, j), 32'(done_o), 32'(j == n));
            check_val($sformatf("dout m%0d d%0h a%0d j%0d", m, d, a, j), 32'(dout_o), 32'(er));
            check_val($sformatf("carry m%0d d%0h a%0d j%0d", m, d, a, j), 32'(carry_out_o), 32'(ec));
        end
    endtask

    initial begin
        #1;
        check_val("reset busy", 32'(busy_o), 32'd0);
        check_val("reset done", 32'(done_o), 32'd0);
        check_val("reset dout", 32'(dout_o), 32'd0);
        check_val("reset carry", 32'(carry_out_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_op(8'h96, 3'b001, 3'd3, 16'h0, 0);
        check_val("shl result", 32'(dout_o), 32'hB0);
        check_val("shl carry", 32'(carry_out_o), 32'd0);
        run_op(8'h96, 3'b101, 3'd2, 16'h0, 0);
        check_val("asr result", 32'(dout_o), 32'hE5);
        check_val("asr carry", 32'(carry_out_o), 32'd1);
        run_op(8'h81, 3'b011, 3'd1, 16'h0, 0);
        check_val("ror result", 32'(dout_o), 32'hC0);
        check_val("ror carry", 32'(carry_out_o), 32'd1);
        run_op(8'h81, 3'b100, 3'd7, 16'h0, 0);
        check_val("rol result", 32'(dout_o), 32'hC0);
        check_val("rol carry", 32'(carry_out_o), 32'd0);
        run_op(8'h5A, 3'b011, 3'd0, 16'h0, 0);
        check_val("ror0 result", 32'(dout_o), 32'h5A);
        run_op(8'h00, 3'b111, 3'd4, 16'hFFFF, 0);
        check_val("fill1 result", 32'(dout_o), 32'hF0);
        check_val("fill1 carry", 32'(carry_out_o), 32'd0);
        run_op(8'h00, 3'b111, 3'd4, 16'h0005, 0);
        check_val("filltog result", 32'(dout_o), 32'h50);
        run_op(8'h3C, 3'b000, 3'd5, 16'h0, 0);
        check_val("pass result", 32'(dout_o), 32'h3C);

        // Ignored starts while busy, then an immediate back-to-back accept.
        run_op(8'h96, 3'b001, 3'd3, 16'h0, 2);
        check_val("hs result", 32'(dout_o), 32'hB0);
        run_op(8'h12, 3'b010, 3'd1, 16'h0, 0);
        check_val("b2b result", 32'(dout_o), 32'h09);

        // Reset in the middle of a shift.
        start_i = 1'b1; din_i = 8'hA5; mode_i = 3'b001; amt_i = 3'd6;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check_val("midrst busy", 32'(busy_o), 32'd0);
        check_val("midrst done", 32'(done_o), 32'd0);
        check_val("midrst dout", 32'(dout_o), 32'd0);
        check_val("midrst carry", 32'(carry_out_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            check_val("postrst done", 32'(done_o), 32'd0);
            check_val("postrst busy", 32'(busy_o), 32'd0);
        end

        for (int t = 0; t < 60; t++) begin
            run_op(W'($urandom), 3'($urandom), AMT_W'($urandom), 16'($urandom),
                   int'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) @(negedge clk_i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
